// File: rtl/parity_gen_chk_core.sv
// Registered parity generator/checker for one data word.
// Keeps a sticky error flag and a saturating error counter.
module parity_gen_chk_core #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_in,
    input  logic              err_clr,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_out,
    output logic              error,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             gen_par;
    logic             err_det;
    logic             sticky_nxt;
    logic [CNT_W-1:0] count_nxt;

    // Odd parity inverts the XOR so data plus parity holds an odd count of ones
    assign gen_par = ODD_PARITY ? ~^data_in : ^data_in;
    assign err_det = valid_in && (parity_in != gen_par);

    // A new error on the same edge as a clear takes priority
    always_comb begin
        sticky_nxt = err_sticky;
        count_nxt  = err_count;
        if (err_clr) begin
            sticky_nxt = err_det;
            count_nxt  = err_det ? CNT_W'(1) : '0;
        end else if (err_det) begin
            sticky_nxt = 1'b1;
            if (err_count != CNT_MAX) begin
                count_nxt = err_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            parity_out <= 1'b0;
            error      <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            valid_out  <= valid_in;
            error      <= err_det;
            err_sticky <= sticky_nxt;
            err_count  <= count_nxt;
            if (valid_in) begin
                data_out   <= data_in;
                parity_out <= gen_par;
            end
        end
    end

endmodule

// File: tb/tb_parity_gen_chk_core.sv
// Directed bench for parity_gen_chk_core: odd and even instances
// driven from shared stimulus, vector table plus hand sequences.
module tb_parity_gen_chk_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic [7:0] data_in;
    logic       parity_in;
    logic       err_clr;

    logic       o_valid, o_par, o_err, o_sticky;
    logic [7:0] o_data, o_cnt;
    logic       e_valid, e_par, e_err, e_sticky;
    logic [7:0] e_data, e_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parity_gen_chk_core #(.DATA_W(8), .ODD_PARITY(1'b1), .CNT_W(8)) dut_odd (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .parity_in(parity_in), .err_clr(err_clr), .valid_out(o_valid),
        .data_out(o_data), .parity_out(o_par), .error(o_err),
        .err_sticky(o_sticky), .err_count(o_cnt)
    );

    parity_gen_chk_core #(.DATA_W(8), .ODD_PARITY(1'b0), .CNT_W(8)) dut_even (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .parity_in(parity_in), .err_clr(err_clr), .valid_out(e_valid),
        .data_out(e_data), .parity_out(e_par), .error(e_err),
        .err_sticky(e_sticky), .err_count(e_cnt)
    );

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] d;
        logic       pin;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       ep;
        logic       ee;
        logic       es;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic p, input logic c);
        rst_n     = r;
        valid_in  = v;
        data_in   = d;
        parity_in = p;
        err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_cnt;
        logic       ref_odd;
        logic       ref_even;

        // rst, valid, data, pin, clr | valid, data, par, err, sticky, cnt
        tbl[0]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'd1};
        tbl[4]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'd2};
        tbl[7]  = '{1'b1, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst_n, tbl[i].valid, tbl[i].d, tbl[i].pin, tbl[i].clr);
            chk($sformatf("v%0d valid_out", i), 32'(o_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d data_out", i), 32'(o_data), 32'(tbl[i].ed));
            chk($sformatf("v%0d parity_out", i), 32'(o_par), 32'(tbl[i].ep));
            chk($sformatf("v%0d error", i), 32'(o_err), 32'(tbl[i].ee));
            chk($sformatf("v%0d err_sticky", i), 32'(o_sticky), 32'(tbl[i].es));
            chk($sformatf("v%0d err_count", i), 32'(o_cnt), 32'(tbl[i].ec));
        end

        // Even-parity instance: F0 has even ones, 01 has odd ones
        step(1'b1, 1'b1, 8'hF0, 1'b1, 1'b0);
        chk("even F0 parity_out", 32'(e_par), 32'd0);
        chk("even F0 error", 32'(e_err), 32'd1);
        chk("even F0 sticky", 32'(e_sticky), 32'd1);
        step(1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        chk("even 01 parity_out", 32'(e_par), 32'd1);
        chk("even 01 error", 32'(e_err), 32'd0);
        chk("even 01 valid_out", 32'(e_valid), 32'd1);

        // Saturation on the odd instance: 07 with parity 1 is always an error
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr before sat", 32'(o_cnt), 32'd0);
        exp_cnt = 8'd0;
        for (int n = 1; n <= 300; n++) begin
            step(1'b1, 1'b1, 8'h07, 1'b1, 1'b0);
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            if (n == 254 || n == 255 || n == 256 || n == 300) begin
                chk($sformatf("sat n=%0d err_count", n), 32'(o_cnt), 32'(exp_cnt));
                chk($sformatf("sat n=%0d valid_out", n), 32'(o_valid), 32'd1);
            end
        end
        step(1'b1, 1'b1, 8'h07, 1'b1, 1'b1);
        chk("clr+err err_count", 32'(o_cnt), 32'd1);
        chk("clr+err err_sticky", 32'(o_sticky), 32'd1);
        chk("clr+err error", 32'(o_err), 32'd1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr alone err_count", 32'(o_cnt), 32'd0);
        chk("clr alone err_sticky", 32'(o_sticky), 32'd0);

        // Exhaustive back-to-back sweep against a popcount reference
        for (int d = 0; d < 256; d++) begin
            for (int p = 0; p < 2; p++) begin
                step(1'b1, 1'b1, 8'(d), 1'(p), 1'b0);
                ref_even = ($countones(8'(d)) % 2) == 1;
                ref_odd  = !ref_even;
                if (o_par !== ref_odd || o_err !== (1'(p) != ref_odd)
                    || e_par !== ref_even || e_err !== (1'(p) != ref_even)
                    || o_valid !== 1'b1 || o_data !== 8'(d)) begin
                    chk($sformatf("sweep d=%02h p=%0d odd{v,par,err}", d, p),
                        {o_valid, o_par, o_err},
                        {1'b1, ref_odd, 1'(p) != ref_odd});
                    chk($sformatf("sweep d=%02h p=%0d even{par,err}", d, p),
                        {e_par, e_err}, {ref_even, 1'(p) != ref_even});
                    chk($sformatf("sweep d=%02h p=%0d data_out", d, p),
                        32'(o_data), 32'(d));
                end else begin
                    n_vec++;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
